mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the pipeline memory/writeback stage. It drives an external data memory over a req/ack handshake with variable latency and a bus timeout, instead of assuming a single-cycle data memory. It generates byte enables for byte, half, word and double accesses, and sign- or zero-extends loads. It selects the register-file writeback value and stalls the upstream pipeline while a memory access is outstanding.

Parameters:
AW, 32, address width.
DW, 32, data width; 32 or 64 only; NB = DW/8 byte lanes, LB = log2(NB).
TIMEOUT, 16, maximum cycles mem_req may wait for mem_ack; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  operation presented; accepted only when stall=0.
in_load  in  1  load operation.
in_store  in  1  store operation; in_load and in_store both 1 is treated as load.
in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
in_unsigned  in  1  zero-extend load (1) or sign-extend load (0).
in_addr  in  AW  byte address / ALU result.
in_wdata  in  DW  store data, right-aligned.
in_rf_sel  in  3  writeback select: 000 addr, 010 load data, 011 alu_lo, 100 cp0, 101 hi, others lo.
in_alu_lo  in  DW  writeback source.
in_cp0  in  DW  writeback source.
in_hi  in  DW  writeback source.
in_lo  in  DW  writeback source.
stall  out  1  upstream must hold its operation.
out_valid  out  1  one-cycle pulse; writeback result valid.
out_wb  out  DW  writeback value.
exc_misalign  out  1  qualifies out_valid: illegal or misaligned access.
exc_bus  out  1  qualifies out_valid: timeout.
mem_req  out  1  memory request, registered.
mem_we  out  1  write enable.
mem_be  out  NB  byte enables.
mem_addr  out  AW  address with the low LB bits cleared.
mem_wdata  out  DW  lane-replicated store data.
mem_ack  in  1  memory completion.
mem_rdata  in  DW  full-width read data, valid with mem_ack.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE, counter 0, all outputs 0, stall=0. Reset during BUSY abandons the access and drops mem_req immediately.
- FSM has two states, IDLE and BUSY. stall = (state==BUSY). Accept = in_valid & ~stall.
- Access size is 2^in_size bytes.
  - Illegal when 2^in_size > NB (for example size 11 with DW=32).
  - Misaligned when the in_addr bits [in_size-1:0] are not all zero.
- IDLE, accept, non-memory op: next cycle out_valid=1, out_wb selected per in_rf_sel; state stays IDLE. Latency is 1 cycle.
- IDLE, accept, memory op that is illegal or misaligned: no request is issued. Next cycle out_valid=1, exc_misalign=1, out_wb=0. State stays IDLE.
- IDLE, accept, legal memory op: next cycle state=BUSY, mem_req=1, and mem_we/be/addr/wdata are registered and held constant while BUSY.
  - off = in_addr[LB-1:0].
  - mem_be = ((1<<2^size)-1) << off.
  - mem_wdata = store data replicated into every aligned slot of the access size.
  - mem_be is applied for loads as well.
- BUSY with mem_ack=1: the next edge sets state IDLE and mem_req=0, and pulses out_valid.
  - Load: out_wb = rdata bytes starting at lane off, extended per in_unsigned, when in_rf_sel=010; otherwise the selected source.
  - Store: out_wb is the selected non-memory source.
  - Minimum memory-op latency is 2 cycles (accept -> req, ack -> out_valid).
- mem_ack outside BUSY is ignored. mem_rdata is sampled only on an ack in BUSY.
- Timeout (TIMEOUT>0): the counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When counter==TIMEOUT-1 and no ack: the next edge sets IDLE, mem_req=0, out_valid=1, exc_bus=1, out_wb=0.
  - An ack in that same cycle wins over the timeout.
- Writeback inputs and control fields are captured at accept, so upstream may change them after accept.
- Exceptions are exclusive: at most one of exc_misalign and exc_bus is set, and only together with out_valid.

Decomposition:
- Package mem_access_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - writeback select encodings WB_ADDR, WB_MEM, WB_ALULO, WB_CP0, WB_HI, WB_LO;
  - state enum IDLE/BUSY.
- One sub-module, mem_lane_align: purely combinational. It produces be and replicated wdata from (size, off, wdata), and the extended load value from (size, off, unsigned, rdata).
- The FSM, counter and writeback mux live in the top module.

Test Plan:
- DW=32, rf_sel=101, hi=0x12345678, non-memory op -> out_valid one cycle later with out_wb=0x12345678, mem_req never asserted.
- Load byte signed, addr=0x1003, rdata=0x80FF_FF01, ack after 3 cycles -> mem_be=1000, mem_addr=0x1000, stall=1 for 4 cycles, out_wb=0xFFFFFF80. Repeat with unsigned -> 0x00000080.
- Store half, addr=0x2002, wdata=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF held until ack.
- Load word at addr=0x3001 -> no mem_req, out_valid next cycle with exc_misalign=1, out_wb=0. Size 11 with DW=32 -> same response.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then out_valid with exc_bus=1. Ack in the 4th cycle -> normal completion, exc_bus=0.
- rst pulsed while BUSY -> mem_req and stall drop asynchronously; a later ack is ignored; a new op is accepted normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the memory access unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [2:0] WB_ADDR  = 3'b000;
    localparam logic [2:0] WB_MEM   = 3'b010;
    localparam logic [2:0] WB_ALULO = 3'b011;
    localparam logic [2:0] WB_CP0   = 3'b100;
    localparam logic [2:0] WB_HI    = 3'b101;
    localparam logic [2:0] WB_LO    = 3'b110;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Pipeline-side and memory-side bundle of the memory access unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int NB = DW / 8;

    logic          in_valid;
    logic          in_load;
    logic          in_store;
    logic [1:0]    in_size;
    logic          in_unsigned;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic [2:0]    in_rf_sel;
    logic [DW-1:0] in_alu_lo;
    logic [DW-1:0] in_cp0;
    logic [DW-1:0] in_hi;
    logic [DW-1:0] in_lo;
    logic          stall;
    logic          out_valid;
    logic [DW-1:0] out_wb;
    logic          exc_misalign;
    logic          exc_bus;
    logic          mem_req;
    logic          mem_we;
    logic [NB-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_load, in_store, in_size, in_unsigned, in_addr,
               in_wdata, in_rf_sel, in_alu_lo, in_cp0, in_hi, in_lo,
               mem_ack, mem_rdata,
        output stall, out_valid, out_wb, exc_misalign, exc_bus,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_load, in_store, in_size, in_unsigned, in_addr,
               in_wdata, in_rf_sel, in_alu_lo, in_cp0, in_hi, in_lo,
               mem_ack, mem_rdata,
        input  stall, out_valid, out_wb, exc_misalign, exc_bus,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Byte-enable / store replication and load extraction/extension.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter  int DW = 32,
    localparam int NB = DW / 8,
    localparam int LB = $clog2(NB)
) (
    input  logic [1:0]    st_size_i,
    input  logic [LB-1:0] st_off_i,
    input  logic [DW-1:0] st_wdata_i,
    output logic [NB-1:0] be_o,
    output logic [DW-1:0] wdata_o,
    input  logic [1:0]    ld_size_i,
    input  logic [LB-1:0] ld_off_i,
    input  logic          ld_unsigned_i,
    input  logic [DW-1:0] ld_rdata_i,
    output logic [DW-1:0] ld_data_o
);

    logic [3:0]    w_st_bytes;
    logic [3:0]    w_ld_bytes;
    logic [NB-1:0] w_mask;
    logic [DW-1:0] w_shifted;
    logic          w_sign;

    always_comb begin
        w_st_bytes = size_bytes(st_size_i);
        w_ld_bytes = size_bytes(ld_size_i);
        w_mask     = '0;
        wdata_o    = '0;
        ld_data_o  = '0;
        w_sign     = 1'b0;

        for (int i = 0; i < NB; i++) begin
            w_mask[i] = (i < int'(w_st_bytes));
        end
        be_o = w_mask << st_off_i;

        // Each lane repeats the store byte that sits at the same offset within its slot.
        for (int i = 0; i < NB; i++) begin
            wdata_o[8*i +: 8] = st_wdata_i[8*(i & (int'(w_st_bytes) - 1)) +: 8];
        end

        w_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        for (int i = 0; i < NB; i++) begin
            if (i == int'(w_ld_bytes) - 1) begin
                w_sign = w_shifted[8*i+7];
            end
        end
        for (int i = 0; i < NB; i++) begin
            ld_data_o[8*i +: 8] = (i < int'(w_ld_bytes)) ? w_shifted[8*i +: 8]
                                                        : {8{w_sign & ~ld_unsigned_i}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Memory/writeback stage with req/ack data memory and timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_to_last = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          exc_mis_q, exc_mis_d;
    logic          exc_bus_q, exc_bus_d;
    logic [DW-1:0] wb_q, wb_d;
    logic          we_q, we_d;
    logic [NB-1:0] be_q, be_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ld_q, ld_d;
    logic [1:0]    size_q, size_d;
    logic [LB-1:0] off_q, off_d;
    logic          uns_q, uns_d;
    logic [2:0]    sel_q, sel_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] cp0_q, cp0_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;

    logic          w_accept;
    logic          w_is_mem;
    logic [3:0]    w_bytes;
    logic          w_illegal;
    logic          w_misalign;
    logic [NB-1:0] w_be;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_ld_data;

    function automatic logic [DW-1:0] f_wb_mux(
        input logic [2:0]    sel,
        input logic [DW-1:0] addr,
        input logic [DW-1:0] mem,
        input logic [DW-1:0] alu,
        input logic [DW-1:0] cp0,
        input logic [DW-1:0] hi,
        input logic [DW-1:0] lo
    );
        case (sel)
            WB_ADDR:  return addr;
            WB_MEM:   return mem;
            WB_ALULO: return alu;
            WB_CP0:   return cp0;
            WB_HI:    return hi;
            WB_LO:    return lo;
            default:  return lo;
        endcase
    endfunction

    assign w_accept   = bus.in_valid & (state_q == IDLE);
    assign w_is_mem   = bus.in_load | bus.in_store;
    assign w_bytes    = size_bytes(bus.in_size);
    assign w_illegal  = int'(w_bytes) > NB;
    assign w_misalign = |(bus.in_addr[2:0] & 3'(w_bytes - 4'd1));

    mem_lane_align #(.DW(DW)) u_align (
        .st_size_i     (bus.in_size),
        .st_off_i      (bus.in_addr[LB-1:0]),
        .st_wdata_i    (bus.in_wdata),
        .be_o          (w_be),
        .wdata_o       (w_wdata),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (bus.mem_rdata),
        .ld_data_o     (w_ld_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        exc_mis_d = 1'b0;
        exc_bus_d = 1'b0;
        wb_d      = '0;
        we_d      = we_q;
        be_d      = be_q;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        ld_d      = ld_q;
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        alu_d     = alu_q;
        cp0_d     = cp0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    // Upstream may move on after accept, so everything needed later is held here.
                    ld_d   = bus.in_load;
                    size_d = bus.in_size;
                    off_d  = bus.in_addr[LB-1:0];
                    uns_d  = bus.in_unsigned;
                    sel_d  = bus.in_rf_sel;
                    addr_d = DW'(bus.in_addr);
                    alu_d  = bus.in_alu_lo;
                    cp0_d  = bus.in_cp0;
                    hi_d   = bus.in_hi;
                    lo_d   = bus.in_lo;
                    if (!w_is_mem) begin
                        valid_d = 1'b1;
                        wb_d    = f_wb_mux(bus.in_rf_sel, DW'(bus.in_addr), '0, bus.in_alu_lo,
                                           bus.in_cp0, bus.in_hi, bus.in_lo);
                    end else if (w_illegal || w_misalign) begin
                        valid_d   = 1'b1;
                        exc_mis_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        we_d    = ~bus.in_load;
                        be_d    = w_be;
                        maddr_d = {bus.in_addr[AW-1:LB], {LB{1'b0}}};
                        wdata_d = w_wdata;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    wb_d    = f_wb_mux(sel_q, addr_q, ld_q ? w_ld_data : '0, alu_q,
                                       cp0_q, hi_q, lo_q);
                end else if (TIMEOUT > 0 && cnt_q == c_to_last) begin
                    state_d   = IDLE;
                    valid_d   = 1'b1;
                    exc_bus_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            exc_mis_q <= 1'b0;
            exc_bus_q <= 1'b0;
            wb_q      <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            ld_q      <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            uns_q     <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            alu_q     <= '0;
            cp0_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            exc_mis_q <= exc_mis_d;
            exc_bus_q <= exc_bus_d;
            wb_q      <= wb_d;
            we_q      <= we_d;
            be_q      <= be_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            ld_q      <= ld_d;
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            alu_q     <= alu_d;
            cp0_q     <= cp0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.stall        = (state_q == BUSY);
    assign bus.mem_req      = (state_q == BUSY);
    assign bus.out_valid    = valid_q;
    assign bus.out_wb       = wb_q;
    assign bus.exc_misalign = exc_mis_q;
    assign bus.exc_bus      = exc_bus_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_be       = be_q;
    assign bus.mem_addr     = maddr_q;
    assign bus.mem_wdata    = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit (DW=32, TIMEOUT=4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.AW(32), .DW(32)) bus ();

    mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_load     = 1'b0;
        bus.in_store    = 1'b0;
        bus.in_size     = 2'b00;
        bus.in_unsigned = 1'b0;
        bus.in_addr     = '0;
        bus.in_wdata    = '0;
        bus.in_rf_sel   = 3'b000;
        bus.in_alu_lo   = '0;
        bus.in_cp0      = '0;
        bus.in_hi       = '0;
        bus.in_lo       = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    // Presents one operation for a single accepting edge; returns at the following negedge.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] sel);
        @(negedge clk);
        bus.in_load     = ld;
        bus.in_store    = st;
        bus.in_size     = sz;
        bus.in_unsigned = uns;
        bus.in_addr     = addr;
        bus.in_wdata    = wd;
        bus.in_rf_sel   = sel;
        bus.in_valid    = 1'b1;
        @(negedge clk);
        bus.in_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", bus.stall); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h want 0", bus.mem_req); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", bus.out_valid); end
        checks++; if (bus.out_wb !== 32'h0) begin errors++; $display("FAIL reset_wb: got %h want 0", bus.out_wb); end
        checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %b want 0000", bus.mem_be); end
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_valid: got %0h want 0", bus.out_valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_req: got %0h want 0", bus.mem_req); end
    endtask

    task automatic test_nonmem();
        bus.in_hi = 32'h1234_5678;
        bus.in_lo = 32'hDEAD_0000;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 3'b101);
        bus.in_hi = 32'h0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid: got %0h want 1", bus.out_valid); end
        checks++; if (bus.out_wb !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_wb: got %h want 12345678", bus.out_wb); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req: got %0h want 0", bus.mem_req); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nonmem_pulse: got %0h want 0", bus.out_valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req2: got %0h want 0", bus.mem_req); end
    endtask

    // Ack raised in the 4th busy cycle, which is also the last cycle before the timeout.
    task automatic test_load_byte(input logic uns, input logic [31:0] exp);
        int stall_cycles;
        stall_cycles = 0;
        issue(1'b1, 1'b0, 2'b00, uns, 32'h0000_1003, 32'h0, 3'b010);
        bus.in_rf_sel   = 3'b101;
        bus.in_unsigned = ~uns;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL lb_req: got %0h want 1", bus.mem_req); end
        checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b want 1000", bus.mem_be); end
        checks++; if (bus.mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %0h want 0", bus.mem_we); end
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.stall === 1'b1) stall_cycles++;
            if (c == 4) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'h80FF_FF01;
            end
        end
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        checks++; if (stall_cycles != 4) begin errors++; $display("FAIL lb_stall_cycles: got %0d want 4", stall_cycles); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %0h want 1", bus.out_valid); end
        checks++; if (bus.out_wb !== exp) begin errors++; $display("FAIL lb_wb: got %h want %h", bus.out_wb, exp); end
        checks++; if (bus.exc_bus !== 1'b0) begin errors++; $display("FAIL lb_exc_bus: got %0h want 0", bus.exc_bus); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lb_stall_end: got %0h want 0", bus.stall); end
    endtask

    task automatic test_store_half();
        bus.in_alu_lo = 32'hA5A5_0001;
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 3'b011);
        bus.in_wdata  = 32'h0;
        bus.in_alu_lo = 32'h0;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %0h want 1", bus.mem_we); end
        checks++; if (bus.mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h want beefbeef", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h want 00002000", bus.mem_addr); end
        @(negedge clk);
        checks++; if (bus.mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata_hold: got %h want beefbeef", bus.mem_wdata); end
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL sh_req_hold: got %0h want 1", bus.mem_req); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sh_valid: got %0h want 1", bus.out_valid); end
        checks++; if (bus.out_wb !== 32'hA5A5_0001) begin errors++; $display("FAIL sh_wb: got %h want a5a50001", bus.out_wb); end
    endtask

    task automatic test_misalign(input logic [1:0] sz, input logic [31:0] addr);
        bus.in_hi = 32'h5555_AAAA;
        issue(1'b1, 1'b0, sz, 1'b0, addr, 32'h0, 3'b101);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_req sz=%0d: got %0h want 0", sz, bus.mem_req); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mis_valid sz=%0d: got %0h want 1", sz, bus.out_valid); end
        checks++; if (bus.exc_misalign !== 1'b1) begin errors++; $display("FAIL mis_exc sz=%0d: got %0h want 1", sz, bus.exc_misalign); end
        checks++; if (bus.out_wb !== 32'h0) begin errors++; $display("FAIL mis_wb sz=%0d: got %h want 0", sz, bus.out_wb); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mis_stall sz=%0d: got %0h want 0", sz, bus.stall); end
        @(negedge clk);
        bus.in_hi = 32'h0;
        checks++; if (bus.exc_misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse sz=%0d: got %0h want 0", sz, bus.exc_misalign); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        bus.in_lo = 32'h7777_7777;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 3'b010);
        for (int c = 0; c < 10 && bus.mem_req === 1'b1; c++) begin
            req_cycles++;
            @(negedge clk);
        end
        checks++; if (req_cycles != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %0h want 1", bus.out_valid); end
        checks++; if (bus.exc_bus !== 1'b1) begin errors++; $display("FAIL to_exc_bus: got %0h want 1", bus.exc_bus); end
        checks++; if (bus.exc_misalign !== 1'b0) begin errors++; $display("FAIL to_exc_mis: got %0h want 0", bus.exc_misalign); end
        checks++; if (bus.out_wb !== 32'h0) begin errors++; $display("FAIL to_wb: got %h want 0", bus.out_wb); end
        @(negedge clk);
        bus.in_lo = 32'h0;
        checks++; if (bus.exc_bus !== 1'b0) begin errors++; $display("FAIL to_pulse: got %0h want 0", bus.exc_bus); end
    endtask

    task automatic test_reset_busy();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 3'b010);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rb_req_before: got %0h want 1", bus.mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rb_req_async: got %0h want 0", bus.mem_req); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rb_stall_async: got %0h want 0", bus.stall); end
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rb_late_ack_valid: got %0h want 0", bus.out_valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rb_late_ack_req: got %0h want 0", bus.mem_req); end
        bus.in_cp0 = 32'hC0C0_0001;
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b100);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rb_new_valid: got %0h want 1", bus.out_valid); end
        checks++; if (bus.out_wb !== 32'hC0C0_0001) begin errors++; $display("FAIL rb_new_wb: got %h want c0c00001", bus.out_wb); end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_misalign(2'b10, 32'h0000_3001);
        test_misalign(2'b11, 32'h0000_3000);
        test_timeout();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
